// File: rtl/axi_sram_slave.sv
// -----------------------------------------------------------------------------
// axi_sram_slave
//
// AXI responder backed by an internal 2^AW x 32-bit SRAM. The read channel
// (AR/R) and write channel (AW/W/B) run independent state machines, so a read
// burst and a write burst can be in flight at the same time.
//
// Ports
//   aclk, areset                  clock, asynchronous active-high reset
//   ar* / arvalid / arready       read address channel
//   rid/rdata/rresp/rlast/rvalid  read data channel, rready from master
//   aw* / awvalid / awready       write address channel
//   wid/wdata/wstrb/wlast/wvalid  write data channel, wready to master
//   bid/bresp/bvalid              write response channel, bready from master
//
// Every access is a full 32-bit word: size is ignored, the address step is 4,
// FIXED bursts keep the address and every other burst type increments it.
// Address bits above the array and the byte offset are ignored (aliasing).
// -----------------------------------------------------------------------------
module axi_sram_slave #(
   parameter int AW = 10
) (
   input  logic        aclk,
   input  logic        areset,
   // read address
   input  logic [3:0]  arid,
   input  logic [31:0] araddr,
   input  logic [7:0]  arlen,
   input  logic [2:0]  arsize,
   input  logic [1:0]  arburst,
   input  logic [1:0]  arlock,
   input  logic [3:0]  arcache,
   input  logic [2:0]  arprot,
   input  logic        arvalid,
   output logic        arready,
   // read data
   output logic [3:0]  rid,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic        rvalid,
   input  logic        rready,
   // write address
   input  logic [3:0]  awid,
   input  logic [31:0] awaddr,
   input  logic [7:0]  awlen,
   input  logic [2:0]  awsize,
   input  logic [1:0]  awburst,
   input  logic [1:0]  awlock,
   input  logic [3:0]  awcache,
   input  logic [2:0]  awprot,
   input  logic        awvalid,
   output logic        awready,
   // write data
   input  logic [3:0]  wid,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wlast,
   input  logic        wvalid,
   output logic        wready,
   // write response
   output logic [3:0]  bid,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);

   localparam int DEPTH = 2 ** AW;

   localparam logic [0:0] R_IDLE = 1'b0;
   localparam logic [0:0] R_DATA = 1'b1;

   localparam logic [1:0] W_IDLE = 2'd0;
   localparam logic [1:0] W_DATA = 2'd1;
   localparam logic [1:0] W_RESP = 2'd2;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // ---------------------------------------------------------------- read side
   logic [0:0]    r_state_reg;
   logic [AW-1:0] r_idx_reg;
   logic [7:0]    r_cnt_reg;
   logic          r_fixed_reg;
   logic [AW-1:0] r_idx_next;
   logic [AW-1:0] rd_idx;
   logic [31:0]   rd_word;
   logic          ar_hs;
   logic          r_hs;

   // ---------------------------------------------------------------- write side
   logic [1:0]    w_state_reg;
   logic [AW-1:0] w_idx_reg;
   logic [7:0]    w_cnt_reg;
   logic          w_fixed_reg;
   logic          w_err_reg;
   logic          aw_hs;
   logic          mem_we;
   logic          w_final;
   logic          w_beat_err;

   assign ar_hs = arvalid & arready;
   assign r_hs  = rvalid & rready;
   assign aw_hs = awvalid & awready;

   // wready is only ever high in W_DATA, so the handshake alone is the enable.
   assign mem_we     = wvalid & wready;
   assign w_final    = (w_cnt_reg == 8'd0);
   assign w_beat_err = wlast ^ w_final;

   assign rresp = RESP_OKAY;

   // The word loaded into rdata: the AR address when idle, otherwise the
   // address of the beat that follows the one currently presented.
   always_comb begin
      r_idx_next = r_fixed_reg ? r_idx_reg : r_idx_reg + AW'(1);
      rd_idx     = (r_state_reg == R_IDLE) ? araddr[AW+1:2] : r_idx_next;
   end

   // One byte-wide array per lane keeps the strobed write a plain per-array
   // write enable. The read is sampled into rdata by the read FSM, so a write
   // to the same word on the same edge leaves rdata with the old contents.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] mem_lane [0:DEPTH-1];

         always_ff @(posedge aclk) begin
            if (mem_we && wstrb[gi]) begin
               mem_lane[w_idx_reg] <= wdata[gi*8 +: 8];
            end
         end

         assign rd_word[gi*8 +: 8] = mem_lane[rd_idx];
      end
   endgenerate

   // ------------------------------------------------------------- read FSM
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_state_reg <= R_IDLE;
         r_idx_reg   <= '0;
         r_cnt_reg   <= 8'd0;
         r_fixed_reg <= 1'b0;
         arready     <= 1'b0;
         rvalid      <= 1'b0;
         rlast       <= 1'b0;
         rid         <= 4'd0;
         rdata       <= 32'd0;
      end else begin
         case (r_state_reg)
            R_IDLE: begin
               if (ar_hs) begin
                  rid         <= arid;
                  r_idx_reg   <= araddr[AW+1:2];
                  r_cnt_reg   <= arlen;
                  r_fixed_reg <= (arburst == 2'b00);
                  rdata       <= rd_word;
                  rlast       <= (arlen == 8'd0);
                  rvalid      <= 1'b1;
                  arready     <= 1'b0;
                  r_state_reg <= R_DATA;
               end else begin
                  arready <= 1'b1;
               end
            end
            R_DATA: begin
               if (r_hs) begin
                  if (rlast) begin
                     rvalid      <= 1'b0;
                     rlast       <= 1'b0;
                     arready     <= 1'b1;
                     r_state_reg <= R_IDLE;
                  end else begin
                     r_idx_reg <= r_idx_next;
                     rdata     <= rd_word;
                     r_cnt_reg <= r_cnt_reg - 8'd1;
                     // remaining count of 1 means the beat being loaded is last
                     rlast     <= (r_cnt_reg == 8'd1);
                  end
               end
            end
            default: r_state_reg <= R_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------ write FSM
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         w_state_reg <= W_IDLE;
         w_idx_reg   <= '0;
         w_cnt_reg   <= 8'd0;
         w_fixed_reg <= 1'b0;
         w_err_reg   <= 1'b0;
         awready     <= 1'b0;
         wready      <= 1'b0;
         bvalid      <= 1'b0;
         bid         <= 4'd0;
         bresp       <= RESP_OKAY;
      end else begin
         case (w_state_reg)
            W_IDLE: begin
               if (aw_hs) begin
                  bid         <= awid;
                  w_idx_reg   <= awaddr[AW+1:2];
                  w_cnt_reg   <= awlen;
                  w_fixed_reg <= (awburst == 2'b00);
                  w_err_reg   <= 1'b0;
                  awready     <= 1'b0;
                  wready      <= 1'b1;
                  w_state_reg <= W_DATA;
               end else begin
                  awready <= 1'b1;
               end
            end
            W_DATA: begin
               if (mem_we) begin
                  // The burst length is authoritative; wlast only feeds the
                  // error flag.
                  if (w_final) begin
                     wready      <= 1'b0;
                     bvalid      <= 1'b1;
                     bresp       <= (w_err_reg | w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                     w_state_reg <= W_RESP;
                  end else begin
                     w_idx_reg <= w_fixed_reg ? w_idx_reg : w_idx_reg + AW'(1);
                     w_cnt_reg <= w_cnt_reg - 8'd1;
                     w_err_reg <= w_err_reg | w_beat_err;
                  end
               end
            end
            W_RESP: begin
               if (bready) begin
                  bvalid      <= 1'b0;
                  awready     <= 1'b1;
                  w_state_reg <= W_IDLE;
               end
            end
            default: w_state_reg <= W_IDLE;
         endcase
      end
   end

   // Inputs that carry no meaning for this responder.
   logic unused_ok;
   assign unused_ok = ^{araddr[31:AW+2], araddr[1:0], arsize, arburst[1], arlock, arcache, arprot,
                        awaddr[31:AW+2], awaddr[1:0], awsize, awburst[1], awlock, awcache, awprot,
                        wid};

endmodule
